// File: rtl/hazard_unit.sv
// hazard_unit: hazard controller for the 5-stage MIPS core.
// It produces the EX-stage forwarding selects, load-use stall, branch flush
// and halt/drain control, and it keeps the cycle, stall and flush counters.
module hazard_unit #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_halt,
    input  logic [9:0]       ex_src_reg_num,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             go,
    output logic             load_use,
    output logic             pc_dst,
    output logic             halt,
    output logic             pc_stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] load_use_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Drain counter holds values 0 .. DRAIN_CYCLES-1.
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_drain_cnt;
    logic [DW-1:0]   w_drain_cnt_nxt;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_load_use_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic            w_lu_raw;
    logic            w_load_use;
    logic            w_halt_accept;
    logic            w_halt;

    // EX_MEM result is newer than MEM_WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] m_rd,
        input logic       m_we,
        input logic [4:0] w_rd,
        input logic       w_we
    );
        if (m_we && (m_rd != 5'd0) && (m_rd == src))
            return 2'b01;
        else if (w_we && (w_rd != 5'd0) && (w_rd == src))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // Forwarding selects for both EX operands.
    always_comb begin
        fwd_a = fwd_sel(ex_src_reg_num[9:5], mem_rd, mem_reg_write, wb_rd, wb_reg_write);
        fwd_b = fwd_sel(ex_src_reg_num[4:0], mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    end

    // Hazard detection: a taken branch squashes the dependent ID instruction,
    // so neither the stall nor the halt request survives it.
    always_comb begin
        w_lu_raw = ex_mem_read && (ex_rd != 5'd0) &&
                   ((id_use_rs && (ex_rd == id_rs)) || (id_use_rt && (ex_rd == id_rt)));
        w_load_use    = w_lu_raw && !ex_branch_taken && (r_state == S_RUN);
        w_halt_accept = (r_state == S_RUN) && id_halt && !ex_branch_taken;
        w_halt        = w_halt_accept || (r_state != S_RUN);
    end

    assign load_use     = w_load_use;
    assign pc_dst       = ex_branch_taken;
    assign halt         = w_halt;
    assign pc_stall     = w_load_use || w_halt;
    assign halted       = (r_state == S_HALTED);
    assign cycle_cnt    = r_cycle_cnt;
    assign load_use_cnt = r_load_use_cnt;
    assign flush_cnt    = r_flush_cnt;

    // Next-state logic for the halt/drain machine.
    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        unique case (r_state)
            S_RUN: begin
                if (w_halt_accept) begin
                    w_state_nxt     = S_DRAIN;
                    w_drain_cnt_nxt = DW'(DRAIN_CYCLES - 1);
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == '0)
                    w_state_nxt = S_HALTED;
                else
                    w_drain_cnt_nxt = r_drain_cnt - DW'(1);
            end
            S_HALTED: begin
                if (go)
                    w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt     = S_RUN;
                w_drain_cnt_nxt = '0;
            end
        endcase
    end

    // State register; reset overrides go and id_halt.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
        end
    end

    // Performance counters, wrapping at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_cnt    <= '0;
            r_load_use_cnt <= '0;
            r_flush_cnt    <= '0;
        end else begin
            if (r_state != S_HALTED)
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if (w_load_use)
                r_load_use_cnt <= r_load_use_cnt + CNT_W'(1);
            if (ex_branch_taken && (r_state != S_HALTED))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and randomized checks of hazard_unit against a
// behavioural model; a second instance with 4-bit counters checks wrapping.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rd, mem_rd, wb_rd;
    logic        id_use_rs, id_use_rt, id_halt;
    logic [9:0]  ex_src_reg_num;
    logic        ex_mem_read, ex_branch_taken, mem_reg_write, wb_reg_write, go;

    logic        load_use, pc_dst, halt, pc_stall, halted;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] cycle_cnt, load_use_cnt, flush_cnt;

    logic        s_load_use, s_pc_dst, s_halt, s_pc_stall, s_halted;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [3:0]  s_cycle_cnt, s_load_use_cnt, s_flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_unit #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_halt(id_halt),
        .ex_src_reg_num(ex_src_reg_num), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .go(go),
        .load_use(load_use), .pc_dst(pc_dst), .halt(halt), .pc_stall(pc_stall),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .cycle_cnt(cycle_cnt),
        .load_use_cnt(load_use_cnt), .flush_cnt(flush_cnt)
    );

    hazard_unit #(.DRAIN_CYCLES(3), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_halt(id_halt),
        .ex_src_reg_num(ex_src_reg_num), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .go(go),
        .load_use(s_load_use), .pc_dst(s_pc_dst), .halt(s_halt), .pc_stall(s_pc_stall),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .halted(s_halted), .cycle_cnt(s_cycle_cnt),
        .load_use_cnt(s_load_use_cnt), .flush_cnt(s_flush_cnt)
    );

    // Reference model: "running" flag plus a countdown of edges left before
    // the core is stopped (-1 = no halt pending); counters as plain integers.
    bit          m_stopped;
    int          m_edges_to_stop;
    int unsigned m_cyc, m_lu, m_fl;

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (mem_reg_write && mem_rd != 0 && mem_rd == src) return 2'b01;
        if (wb_reg_write && wb_rd != 0 && wb_rd == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit ref_running();
        return !m_stopped && (m_edges_to_stop < 0);
    endfunction

    function automatic bit ref_load_use();
        bit dep;
        dep = (id_use_rs && ex_rd == id_rs) || (id_use_rt && ex_rd == id_rt);
        return ex_mem_read && ex_rd != 0 && dep && !ex_branch_taken && ref_running();
    endfunction

    function automatic bit ref_halt();
        return !ref_running() || (id_halt && !ex_branch_taken);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Combinational outputs for the current inputs, sampled mid-cycle.
    task automatic step_pre();
        bit lu, h;
        #1;
        lu = ref_load_use();
        h  = ref_halt();
        chk("fwd_a",    {30'd0, fwd_a},    {30'd0, ref_fwd(ex_src_reg_num[9:5])});
        chk("fwd_b",    {30'd0, fwd_b},    {30'd0, ref_fwd(ex_src_reg_num[4:0])});
        chk("load_use", {31'd0, load_use}, {31'd0, lu});
        chk("pc_dst",   {31'd0, pc_dst},   {31'd0, ex_branch_taken});
        chk("halt",     {31'd0, halt},     {31'd0, h});
        chk("pc_stall", {31'd0, pc_stall}, {31'd0, lu | h});
        chk("s_halt",   {31'd0, s_halt},   {31'd0, h});
    endtask

    // Advance one clock, update the model, then check the registered outputs.
    task automatic step_post();
        bit lu, was_stopped;
        lu = ref_load_use();
        was_stopped = m_stopped;
        @(posedge clk);
        if (reset) begin
            m_stopped = 0; m_edges_to_stop = -1;
            m_cyc = 0; m_lu = 0; m_fl = 0;
        end else begin
            if (!was_stopped) m_cyc++;
            if (lu) m_lu++;
            if (ex_branch_taken && !was_stopped) m_fl++;
            if (m_stopped) begin
                if (go) m_stopped = 0;
            end else if (m_edges_to_stop == 0) begin
                m_stopped = 1; m_edges_to_stop = -1;
            end else if (m_edges_to_stop > 0) begin
                m_edges_to_stop--;
            end else if (id_halt && !ex_branch_taken) begin
                m_edges_to_stop = 2;
            end
        end
        #1;
        chk("halted",         {31'd0, halted},          {31'd0, m_stopped});
        chk("cycle_cnt",      cycle_cnt,                m_cyc);
        chk("load_use_cnt",   load_use_cnt,             m_lu);
        chk("flush_cnt",      flush_cnt,                m_fl);
        chk("s_cycle_cnt",    {28'd0, s_cycle_cnt},     m_cyc & 32'hF);
        chk("s_load_use_cnt", {28'd0, s_load_use_cnt},  m_lu & 32'hF);
        chk("s_flush_cnt",    {28'd0, s_flush_cnt},     m_fl & 32'hF);
    endtask

    task automatic tick();
        step_pre();
        step_post();
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_halt = 0;
        ex_src_reg_num = 0; ex_rd = 0; ex_mem_read = 0; ex_branch_taken = 0;
        mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0; go = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned frozen, lu0, fl0;
        idle_inputs();
        reset = 1;
        m_stopped = 0; m_edges_to_stop = -1; m_cyc = 0; m_lu = 0; m_fl = 0;
        @(posedge clk); @(posedge clk); #1;
        reset = 0;

        // Reset state with idle inputs.
        step_pre();
        chk("rst_load_use", {31'd0, load_use}, 32'd0);
        chk("rst_halt",     {31'd0, halt},     32'd0);
        chk("rst_pc_stall", {31'd0, pc_stall}, 32'd0);
        chk("rst_fwd_a",    {30'd0, fwd_a},    32'd0);
        chk("rst_halted",   {31'd0, halted},   32'd0);
        chk("rst_cycle",    cycle_cnt,         32'd0);
        step_post();

        // Forward priority: EX_MEM beats MEM_WB.
        ex_src_reg_num = {5'd8, 5'd9};
        mem_rd = 8; mem_reg_write = 1; wb_rd = 9; wb_reg_write = 1;
        step_pre();
        chk("fwd_prio_a", {30'd0, fwd_a}, 32'd1);
        chk("fwd_prio_b", {30'd0, fwd_b}, 32'd2);
        step_post();
        mem_rd = 0; wb_rd = 8;
        step_pre();
        chk("fwd_r0_a", {30'd0, fwd_a}, 32'd2);
        chk("fwd_r0_b", {30'd0, fwd_b}, 32'd0);
        step_post();
        idle_inputs();

        // Load-use stall.
        lu0 = m_lu;
        ex_mem_read = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
        step_pre();
        chk("lu_stall",  {31'd0, load_use}, 32'd1);
        chk("lu_pcstal", {31'd0, pc_stall}, 32'd1);
        step_post();
        chk("lu_cnt_inc", load_use_cnt, lu0 + 1);
        id_use_rs = 0;
        step_pre();
        chk("lu_unused", {31'd0, load_use}, 32'd0);
        step_post();

        // Branch overrides load-use.
        lu0 = m_lu; fl0 = m_fl;
        id_use_rs = 1; ex_branch_taken = 1;
        step_pre();
        chk("br_lu",     {31'd0, load_use}, 32'd0);
        chk("br_pc_dst", {31'd0, pc_dst},   32'd1);
        step_post();
        chk("br_fl_cnt", flush_cnt,    fl0 + 1);
        chk("br_lu_cnt", load_use_cnt, lu0);
        idle_inputs();

        // Halt drain, freeze, resume.
        id_halt = 1;
        step_pre();
        chk("hlt_early", {31'd0, halt}, 32'd1);
        step_post();
        id_halt = 0;
        chk("hlt_n1", {31'd0, halted}, 32'd0);
        tick(); chk("hlt_n2", {31'd0, halted}, 32'd0);
        tick(); chk("hlt_n3", {31'd0, halted}, 32'd0);
        tick(); chk("hlt_set", {31'd0, halted}, 32'd1);
        frozen = cycle_cnt;
        repeat (5) tick();
        chk("hlt_frozen", cycle_cnt, frozen);
        go = 1;
        tick();
        go = 0;
        chk("go_halted", {31'd0, halted}, 32'd0);
        step_pre();
        chk("go_halt", {31'd0, halt}, 32'd0);
        step_post();
        chk("go_resume", cycle_cnt, frozen + 1);

        // Halt killed by a taken branch.
        id_halt = 1; ex_branch_taken = 1;
        step_pre();
        chk("kill_halt", {31'd0, halt}, 32'd0);
        step_post();
        idle_inputs();
        repeat (4) begin
            tick();
            chk("kill_halted", {31'd0, halted}, 32'd0);
        end

        // Reset one cycle into DRAIN.
        id_halt = 1; tick(); id_halt = 0;
        tick();
        reset = 1; tick(); reset = 0;
        chk("rst_mid_cyc", cycle_cnt, 32'd0);
        chk("rst_mid_fl",  flush_cnt, 32'd0);
        repeat (4) begin
            tick();
            chk("rst_mid_halted", {31'd0, halted}, 32'd0);
        end

        // 4-bit counter wraps after 16 RUN cycles from reset.
        reset = 1; tick(); reset = 0;
        repeat (16) tick();
        chk("wrap16", {28'd0, s_cycle_cnt}, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            id_rs           = 5'($urandom_range(0, 6));
            id_rt           = 5'($urandom_range(0, 6));
            id_use_rs       = 1'($urandom);
            id_use_rt       = 1'($urandom);
            id_halt         = ($urandom_range(0, 9) == 0);
            ex_src_reg_num  = {5'($urandom_range(0, 6)), 5'($urandom_range(0, 6))};
            ex_rd           = 5'($urandom_range(0, 6));
            ex_mem_read     = 1'($urandom);
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            mem_rd          = 5'($urandom_range(0, 6));
            mem_reg_write   = 1'($urandom);
            wb_rd           = 5'($urandom_range(0, 6));
            wb_reg_write    = 1'($urandom);
            go              = ($urandom_range(0, 3) == 0);
            reset           = ($urandom_range(0, 59) == 0);
            tick();
        end
        reset = 0;
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage MIPS core. It consumes the register-number and destination fields that leave the ID_EX, EX_MEM and MEM_WB pipeline registers. It produces the `load_use`, `PC_dst` flush and `halt` control inputs those registers act on, plus EX-stage forwarding selects. It also owns the halt/drain state machine and the performance counters for total cycles, load-use stalls and branch flushes.

## Interface
- `DRAIN_CYCLES`, default 3: cycles spent draining after a halt before entering HALTED.
- `CNT_W`, default 32: width of each performance counter.

Ports:
- `clk`, in, 1: clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `id_rs`, `id_rt`, in, 5 each: source registers of the instruction in ID.
- `id_use_rs`, `id_use_rt`, in, 1 each: the ID instruction reads that source.
- `id_halt`, in, 1: a syscall-halt is decoded in ID.
- `ex_src_reg_num`, in, 10: ID_EX `src_reg_num_out`; [9:5] is rs, [4:0] is rt.
- `ex_rd`, in, 5: ID_EX `RD_out`.
- `ex_mem_read`, in, 1: the EX instruction is a load.
- `ex_branch_taken`, in, 1: a branch or jump resolved taken in EX.
- `mem_rd`, `mem_reg_write`, in, 5 and 1: EX_MEM destination and write enable.
- `wb_rd`, `wb_reg_write`, in, 5 and 1: MEM_WB destination and write enable.
- `go`, in, 1: resume pulse from the board controller.
- `load_use`, out, 1: to ID_EX; also stalls PC and IF_ID.
- `pc_dst`, out, 1: to ID_EX and IF_ID, flush.
- `halt`, out, 1: to ID_EX, bubble insert.
- `pc_stall`, out, 1: hold PC and IF_ID.
- `fwd_a`, `fwd_b`, out, 2 each: EX operand select. 00 = register file, 01 = EX_MEM, 10 = MEM_WB.
- `halted`, out, 1: the core is stopped.
- `cycle_cnt`, `load_use_cnt`, `flush_cnt`, out, `CNT_W` each: performance counters.

## Operation
- **Forwarding (combinational).** For operand A, compare rs = `ex_src_reg_num[9:5]`.
  - If `mem_reg_write`, `mem_rd`≠0 and `mem_rd`==rs, then `fwd_a`=01.
  - Else if `wb_reg_write`, `wb_rd`≠0 and `wb_rd`==rs, then `fwd_a`=10.
  - Else `fwd_a`=00. EX_MEM has priority over MEM_WB.
  - `fwd_b` uses the same rules with rt = [4:0].
- **Load-use hazard.** Raw condition: `ex_mem_read` & `ex_rd`≠0 & ((`id_use_rs` & `ex_rd`==`id_rs`) | (`id_use_rt` & `ex_rd`==`id_rt`)).
  - `load_use` = raw condition & ~`ex_branch_taken` & (state==RUN).
- **Branch flush.** `pc_dst` = `ex_branch_taken`, passed through with no gating.
- **FSM states:** RUN, DRAIN, HALTED. Register `drain_cnt` is 2 bits wide, or sized to hold `DRAIN_CYCLES`.
  - RUN to DRAIN when `id_halt` & ~`ex_branch_taken`. Load `drain_cnt`=`DRAIN_CYCLES`-1.
  - DRAIN: decrement each cycle. When `drain_cnt`==0, go to HALTED.
  - HALTED to RUN when `go`=1.
  - `go` is ignored in RUN and DRAIN. `id_halt` is ignored outside RUN.
- **Halt and stall outputs.**
  - `halt` = (state==RUN & `id_halt` & ~`ex_branch_taken`) | state≠RUN.
  - `pc_stall` = `load_use` | `halt`.
  - `halted` = (state==HALTED).
- **Counters.** All wrap modulo 2^`CNT_W` and are readable at any time.
  - `cycle_cnt` increments every cycle the state is not HALTED.
  - `load_use_cnt` increments every cycle `load_use`=1.
  - `flush_cnt` increments every cycle `ex_branch_taken`=1 while the state is not HALTED.
- **Simultaneous events.**
  - Branch taken together with `id_halt`: the branch wins. The halt is on the wrong path and is flushed, so there is no state change.
  - Branch taken together with a load-use hazard: `load_use`=0 and `flush_cnt` increments; `load_use_cnt` does not.

## Timing
- **Reset.** State=RUN, `drain_cnt`=0, all counters 0.
  - With inputs idle after reset: `load_use`=0, `pc_dst`=0, `halt`=0, `pc_stall`=0, `fwd_a`=`fwd_b`=00, `halted`=0.
- **Combinational paths.** Forwarding, `load_use` and `pc_dst` have zero latency, valid in the same cycle as their inputs.
- **Halt sequence.** `id_halt` is sampled high at edge N.
  - `halt`=1 already in the cycle before edge N.
  - DRAIN occupies the cycles following edges N, N+1 and N+2.
  - HALTED starts after edge N+3; `halted` rises then.
- **Resume.** `go` high at edge M while HALTED: RUN after edge M and `halted`=0. A `go` pulse is a single cycle; holding it longer has no further effect.
- **Reset priority.** Reset in any state, including mid-DRAIN, returns to RUN and clears the counters at that edge. Reset overrides `go` and `id_halt`.

## Test plan
- **Forward priority.** `ex_src_reg_num`={5'd8,5'd9}, `mem_rd`=8 (write on), `wb_rd`=8 and 9 (write on) -> `fwd_a`=01, `fwd_b`=10. Repeat with `mem_rd`=0: `fwd_a` does not select 01.
- **Load-use.** `ex_mem_read`=1, `ex_rd`=5, `id_rs`=5, `id_use_rs`=1 for 1 cycle -> `load_use`=1, `pc_stall`=1, `load_use_cnt`=1. With `id_use_rs`=0 -> `load_use`=0.
- **Branch over load-use.** Same hazard plus `ex_branch_taken`=1 -> `load_use`=0, `pc_dst`=1, `flush_cnt`=1, `load_use_cnt`=0.
- **Halt drain.** Pulse `id_halt` at edge N -> `halted`=0 at N+1..N+3, `halted`=1 after N+3. `cycle_cnt` then freezes; hold 5 cycles and confirm it is unchanged. Pulse `go` -> RUN, `halt`=0, and `cycle_cnt` resumes.
- **Halt killed by branch.** `id_halt`=1 with `ex_branch_taken`=1 -> state stays RUN, `halt`=0, `halted` never rises.
- **Reset mid-DRAIN.** Reset one cycle after entering DRAIN -> RUN, all counters 0, `halted` stays 0. Also check `cycle_cnt` wrap with `CNT_W`=4: after 16 RUN cycles it reads 0.
